nand2_bist: RTL and testbench

- Built-in self-test engine for the 2-input NAND library cell. It is the driving and checking side of the cell: it generates A/B stimulus, samples Y, compares against a golden NAND, and compacts responses into a MISR signature.
- Sits in the library characterization/test wrapper. One instance per cell-under-test (CUT); results are read by the SoC test controller.

---
 rtl/nand2_bist_pkg.sv | 35 +++
 rtl/nand2_bist_if.sv | 34 +++
 rtl/nand2_bist_misr16.sv | 40 ++++
 rtl/nand2_bist.sv | 166 ++++++++++++++++
 tb/tb_nand2_bist.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/nand2_bist_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : nand2_bist_pkg
//  Purpose  : Shared types and constants for the NAND2 cell BIST engine:
//             FSM state encoding, MISR polynomial/seed, error-count ceiling,
//             and the single-step MISR update function.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package nand2_bist_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        APPLY  = 3'd1,
        WAIT   = 3'd2,
        SAMPLE = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam logic [15:0] MISR_POLY = 16'h1021;
    localparam logic [15:0] MISR_SEED = 16'hFFFF;
    localparam logic [7:0]  ERR_MAX   = 8'd255;

    // One MISR step: shift left, fold the polynomial in when the MSB falls
    // out, then inject the new response bit at the LSB.
    function automatic logic [15:0] misr_step(input logic [15:0] sig,
                                              input logic        din);
        logic [15:0] w_next;
        w_next = {sig[14:0], 1'b0} ^ (sig[15] ? MISR_POLY : 16'h0000);
        w_next = w_next ^ {15'b0, din};
        return w_next;
    endfunction

endpackage
`default_nettype wire

// File: rtl/nand2_bist_if.sv
`default_nettype none
// ============================================================================
//  Module   : nand2_bist_if
//  Purpose  : Bundles the BIST control/status bus and the CUT pin signals.
//  Ports    : start      - run request (controller -> engine)
//             cut_y      - CUT output Y (cell -> engine)
//             cut_a/cut_b- CUT stimulus (engine -> cell)
//             busy, done, pass, err_cnt[7:0], signature[15:0] - status
//             modport slave  : the BIST engine side
//             modport master : controller / cell side
//  Revision : 1.0  initial release
// ============================================================================
interface nand2_bist_if;
    logic        start;
    logic        cut_a;
    logic        cut_b;
    logic        cut_y;
    logic        busy;
    logic        done;
    logic        pass;
    logic [7:0]  err_cnt;
    logic [15:0] signature;

    modport slave (
        input  start, cut_y,
        output cut_a, cut_b, busy, done, pass, err_cnt, signature
    );

    modport master (
        output start, cut_y,
        input  cut_a, cut_b, busy, done, pass, err_cnt, signature
    );
endinterface
`default_nettype wire

// File: rtl/nand2_bist_misr16.sv
`default_nettype none
// ============================================================================
//  Module   : misr16
//  Purpose  : 16-bit multiple-input signature register compacting the CUT
//             response stream.
//  Ports    : CLK   - clock, rising edge
//             R     - synchronous active-low reset (loads the seed)
//             clear - reload the seed (start of a run)
//             en    - fold din into the signature this edge
//             din   - response bit
//             sig   - current signature
//  Revision : 1.0  initial release
// ============================================================================
module misr16
    import nand2_bist_pkg::*;
(
    input  wire logic        CLK,
    input  wire logic        R,
    input  wire logic        clear,
    input  wire logic        en,
    input  wire logic        din,
    output logic [15:0]      sig
);

    logic [15:0] r_sig;

    always_ff @(posedge CLK) begin
        if (!R) begin
            r_sig <= MISR_SEED;
        end else if (clear) begin
            r_sig <= MISR_SEED;
        end else if (en) begin
            r_sig <= misr_step(r_sig, din);
        end
    end

    assign sig = r_sig;

endmodule
`default_nettype wire

// File: rtl/nand2_bist.sv
`default_nettype none
// ============================================================================
//  Module   : nand2_bist
//  Purpose  : BIST engine for a 2-input NAND cell. Applies the exhaustive
//             (A,B) pattern set PASSES times, waits SETTLE cycles per
//             pattern, compares Y against the golden NAND, counts
//             mismatches (saturating) and compacts Y into a MISR signature.
//  Params   : SETTLE - settle cycles before sampling Y (1..15)
//             PASSES - repetitions of the 4-pattern set (1..255)
//  Ports    : CLK - clock, rising edge
//             R   - synchronous active-low reset
//             bus - nand2_bist_if.slave (start, cut_y in; cut_a, cut_b,
//                   busy, done, pass, err_cnt, signature out)
//  Revision : 1.0  initial release
// ============================================================================
module nand2_bist
    import nand2_bist_pkg::*;
#(
    parameter int SETTLE = 2,
    parameter int PASSES = 1
)
(
    input  wire logic        CLK,
    input  wire logic        R,
    nand2_bist_if.slave      bus
);

    localparam logic [3:0] C_SETTLE_LAST = 4'(SETTLE - 1);
    localparam logic [7:0] C_PASS_LAST   = 8'(PASSES - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic        w_launch;
    logic        w_sample;
    logic        w_last;
    logic        w_mismatch;
    logic [7:0]  w_err_next;
    logic [1:0]  w_pat_next;

    logic [1:0]  r_pat;
    logic [7:0]  r_pass_cnt;
    logic [3:0]  r_wait_cnt;
    logic        r_cut_a;
    logic        r_cut_b;
    logic        r_busy;
    logic        r_done;
    logic        r_pass;
    logic [7:0]  r_err;
    logic [15:0] w_sig;

    // ------------------------------------------------------------------
    // Next-state and control strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_launch     = 1'b0;
        w_sample     = 1'b0;
        w_last       = (r_pat == 2'd3) && (r_pass_cnt == C_PASS_LAST);
        unique case (r_state)
            IDLE, DONE: begin
                if (bus.start) begin
                    w_state_next = APPLY;
                    w_launch     = 1'b1;
                end
            end
            APPLY:  w_state_next = WAIT;
            WAIT: begin
                if (r_wait_cnt == C_SETTLE_LAST) begin
                    w_state_next = SAMPLE;
                end
            end
            SAMPLE: begin
                w_sample     = 1'b1;
                w_state_next = w_last ? DONE : APPLY;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Compare against the golden NAND of the pins actually being driven.
    always_comb begin
        w_mismatch = (bus.cut_y != ~(r_cut_a & r_cut_b));
        w_err_next = r_err;
        if (w_mismatch && (r_err != ERR_MAX)) begin
            w_err_next = r_err + 8'd1;
        end
        w_pat_next = r_pat + 2'd1;
    end

    always_ff @(posedge CLK) begin
        if (!R) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Datapath: pattern/pass counters, stimulus, error count, status
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!R) begin
            r_pat      <= 2'd0;
            r_pass_cnt <= 8'd0;
            r_wait_cnt <= 4'd0;
            r_cut_a    <= 1'b0;
            r_cut_b    <= 1'b0;
            r_err      <= 8'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
        end else begin
            // Settle counter restarts every time a pattern is applied.
            if (r_state == APPLY) begin
                r_wait_cnt <= 4'd0;
            end else if (r_state == WAIT) begin
                r_wait_cnt <= r_wait_cnt + 4'd1;
            end

            if (w_launch) begin
                r_pat      <= 2'd0;
                r_pass_cnt <= 8'd0;
                r_cut_a    <= 1'b0;
                r_cut_b    <= 1'b0;
                r_err      <= 8'd0;
                r_busy     <= 1'b1;
                r_done     <= 1'b0;
                r_pass     <= 1'b0;
            end else if (w_sample) begin
                r_err <= w_err_next;
                r_pat <= w_pat_next;
                if (r_pat == 2'd3) begin
                    r_pass_cnt <= r_pass_cnt + 8'd1;
                end
                if (w_last) begin
                    // Stimulus holds the final pattern while parked in DONE.
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                    r_pass <= (w_err_next == 8'd0);
                end else begin
                    r_cut_a <= w_pat_next[1];
                    r_cut_b <= w_pat_next[0];
                end
            end
        end
    end

    misr16 u_misr (
        .CLK   (CLK),
        .R     (R),
        .clear (w_launch),
        .en    (w_sample),
        .din   (bus.cut_y),
        .sig   (w_sig)
    );

    assign bus.cut_a     = r_cut_a;
    assign bus.cut_b     = r_cut_b;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.pass      = r_pass;
    assign bus.err_cnt   = r_err;
    assign bus.signature = w_sig;

endmodule
`default_nettype wire

// File: tb/tb_nand2_bist.sv
`default_nettype none
// ============================================================================
//  Module   : tb_nand2_bist
//  Purpose  : Self-checking bench for nand2_bist. Four engine instances with
//             different SETTLE/PASSES drive modelled NAND cells whose truth
//             table can be faulted; results are compared with a reference
//             computed directly from the pattern set.
//  Revision : 1.0  initial release
// ============================================================================
module tb_nand2_bist;

    localparam logic [3:0] TT_GOOD = 4'b0111;  // index {A,B}: Y for 00,01,10,11
    localparam logic [3:0] TT_SA1  = 4'b1111;
    localparam logic [3:0] TT_SA0  = 4'b0000;

    logic       clk;
    logic       rst_n;
    logic       start_v [4];
    logic [3:0] tt_v    [4];

    wire [3:0]  busy_v;
    wire [3:0]  done_v;
    wire [3:0]  pass_v;
    wire [3:0]  cuta_v;
    wire [3:0]  cutb_v;
    wire [7:0]  err_v [4];
    wire [15:0] sig_v [4];

    int n_tests;
    int n_fail;

    nand2_bist_if bus0 ();
    nand2_bist_if bus1 ();
    nand2_bist_if bus2 ();
    nand2_bist_if bus3 ();

    nand2_bist #(.SETTLE(2), .PASSES(1))   u_dut0 (.CLK(clk), .R(rst_n), .bus(bus0));
    nand2_bist #(.SETTLE(2), .PASSES(3))   u_dut1 (.CLK(clk), .R(rst_n), .bus(bus1));
    nand2_bist #(.SETTLE(2), .PASSES(255)) u_dut2 (.CLK(clk), .R(rst_n), .bus(bus2));
    nand2_bist #(.SETTLE(1), .PASSES(2))   u_dut3 (.CLK(clk), .R(rst_n), .bus(bus3));

    // Cell models: Y looked up from the (possibly faulted) truth table.
    assign bus0.start = start_v[0];
    assign bus1.start = start_v[1];
    assign bus2.start = start_v[2];
    assign bus3.start = start_v[3];
    assign bus0.cut_y = tt_v[0][{bus0.cut_a, bus0.cut_b}];
    assign bus1.cut_y = tt_v[1][{bus1.cut_a, bus1.cut_b}];
    assign bus2.cut_y = tt_v[2][{bus2.cut_a, bus2.cut_b}];
    assign bus3.cut_y = tt_v[3][{bus3.cut_a, bus3.cut_b}];

    assign busy_v = {bus3.busy,  bus2.busy,  bus1.busy,  bus0.busy};
    assign done_v = {bus3.done,  bus2.done,  bus1.done,  bus0.done};
    assign pass_v = {bus3.pass,  bus2.pass,  bus1.pass,  bus0.pass};
    assign cuta_v = {bus3.cut_a, bus2.cut_a, bus1.cut_a, bus0.cut_a};
    assign cutb_v = {bus3.cut_b, bus2.cut_b, bus1.cut_b, bus0.cut_b};
    assign err_v[0] = bus0.err_cnt;
    assign err_v[1] = bus1.err_cnt;
    assign err_v[2] = bus2.err_cnt;
    assign err_v[3] = bus3.err_cnt;
    assign sig_v[0] = bus0.signature;
    assign sig_v[1] = bus1.signature;
    assign sig_v[2] = bus2.signature;
    assign sig_v[3] = bus3.signature;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int settle_of(input int d);
        return (d == 3) ? 1 : 2;
    endfunction

    function automatic int passes_of(input int d);
        case (d)
            0:       return 1;
            1:       return 3;
            2:       return 255;
            default: return 2;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: walk the whole run pattern by pattern.
    task automatic model(input int passes, input logic [3:0] tt,
                         output logic [7:0] err, output logic [15:0] sig);
        int e;
        logic y;
        e   = 0;
        sig = 16'hFFFF;
        for (int p = 0; p < passes; p++) begin
            for (int k = 0; k < 4; k++) begin
                y = tt[k];
                if (y != (k != 3)) e = (e < 255) ? e + 1 : 255;
                sig = {sig[14:0], 1'b0} ^ (sig[15] ? 16'h1021 : 16'h0000) ^ {15'b0, y};
            end
        end
        err = 8'(e);
    endtask

    // Count cycles (sampled 1ns after each edge) until done rises.
    task automatic wait_done(input int d, input int bound, input int pulse_at, output int cyc);
        int s;
        s   = settle_of(d) + 2;
        cyc = 0;
        while (!done_v[d] && cyc < bound) begin
            if (cyc < 4 * s && (cyc % s) == 0)
                check("pattern", {30'b0, cuta_v[d], cutb_v[d]}, 32'((cyc / s) % 4));
            if (pulse_at >= 0) start_v[d] = (cyc == pulse_at);
            @(posedge clk); #1;
            cyc++;
        end
        if (pulse_at >= 0) start_v[d] = 1'b0;
    endtask

    task automatic run(input int d, input logic [3:0] tt, input int pulse_at, output logic [15:0] sig_o);
        logic [7:0]  e_err;
        logic [15:0] e_sig;
        int lat, cyc;
        model(passes_of(d), tt, e_err, e_sig);
        lat = 4 * passes_of(d) * (settle_of(d) + 2);
        tt_v[d]    = tt;
        start_v[d] = 1'b1;
        @(posedge clk); #1;
        start_v[d] = 1'b0;
        check("busy_on", busy_v[d], 1);
        check("done_off", done_v[d], 0);
        wait_done(d, lat + 20, pulse_at, cyc);
        check("latency", cyc, lat);
        check("done", done_v[d], 1);
        check("busy_off", busy_v[d], 0);
        check("err_cnt", err_v[d], e_err);
        check("pass", pass_v[d], (e_err == 8'd0));
        check("signature", sig_v[d], e_sig);
        check("cut_hold", {cuta_v[d], cutb_v[d]}, 2'b11);
        sig_o = sig_v[d];
        @(posedge clk); #1;
        check("done_hold", done_v[d], 1);
    endtask

    task automatic check_reset_state(input int d);
        check("rst_busy", busy_v[d], 0);
        check("rst_done", done_v[d], 0);
        check("rst_pass", pass_v[d], 0);
        check("rst_cut", {cuta_v[d], cutb_v[d]}, 2'b00);
        check("rst_err", err_v[d], 0);
        check("rst_sig", sig_v[d], 16'hFFFF);
    endtask

    task automatic reset_mid_run(input int k, input logic [3:0] tt);
        tt_v[0]    = tt;
        start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        repeat (k) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_reset_state(0);
    endtask

    initial begin
        logic [15:0] sig;
        int cyc;
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            start_v[i] = 1'b0;
            tt_v[i]    = TT_GOOD;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) check_reset_state(i);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cell scenarios with known signatures.
        run(0, TT_GOOD, -1, sig); check("sig_good", sig, 16'h0E11);
        run(0, TT_SA1,  -1, sig); check("sig_sa1",  sig, 16'h0E10);
        run(0, TT_SA0,  -1, sig); check("sig_sa0",  sig, 16'h0E1F);

        // Reset in the WAIT of the third pattern, then a random point.
        reset_mid_run(9, TT_SA0);
        run(0, TT_GOOD, -1, sig); check("sig_after_rst", sig, 16'h0E11);
        reset_mid_run($urandom_range(1, 14), 4'($urandom));

        // Random faulted cells with a start pulse injected while busy.
        for (int i = 0; i < 6; i++)
            run(0, 4'($urandom), $urandom_range(0, 15), sig);

        // start held high straight through DONE.
        tt_v[0]    = TT_GOOD;
        start_v[0] = 1'b1;
        @(posedge clk); #1;
        wait_done(0, 40, -1, cyc);
        check("hold_latency1", cyc, 16);
        check("hold_done1", done_v[0], 1);
        @(posedge clk); #1;
        check("hold_done_1cyc", done_v[0], 0);
        check("hold_busy", busy_v[0], 1);
        check("hold_reseed", sig_v[0], 16'hFFFF);
        start_v[0] = 1'b0;
        wait_done(0, 40, -1, cyc);
        check("hold_latency2", cyc, 16);
        check("hold_sig", sig_v[0], 16'h0E11);

        // Multi-pass and SETTLE=1 instances.
        run(1, TT_GOOD, -1, sig);
        run(2, TT_SA0,  -1, sig);
        check("sat_err", err_v[2], 8'd255);
        run(3, 4'($urandom), $urandom_range(0, 20), sig);
        run(3, TT_GOOD, -1, sig);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
